// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter. Frames are sent back-to-back while
// the FIFO has data; the overflow flag is sticky until reset.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               data_in,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tx
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST = CLKS_PER_BIT - 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;

  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full_q;
  logic            busy_q;
  logic            ovf_q;

  logic            bit_end;
  logic            push;
  logic            pop;
  logic            idle_d;
  logic [CW-1:0]   count_d;
  logic            busy_d;

  // Push/pop decode; a pop only happens when the shifter is free to take a byte.
  always_comb begin
    bit_end = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    idle_d  = 1'b0;
    count_d = count_q;
    busy_d  = 1'b0;

    bit_end = (timer_q == TW'(LAST));
    push    = wr_en && !full_q;
    pop     = (count_q != '0) &&
              ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    idle_d  = ((state_q == IDLE) || ((state_q == STOP) && bit_end)) && !pop;
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = !idle_d || (count_d != '0);
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      busy_q  <= busy_d;
      if (wr_en && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Data storage is left unreset; it is only ever read after being written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_in;
      end
      if (pop) begin
        shift_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Transmit FSM: tx is registered and set together with each state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          idx_q   <= '0;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end else begin
            tx_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            timer_q <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[3'(idx_q + 3'd1)];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer_q <= '0;
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-and-frame-position model of the transmitter.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          FRAME = 10 * int'(CPB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          full;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;
  logic          tx;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes, and the byte currently on the line with its cycle position.
  logic [7:0] mq [$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .full     (full),
    .count    (count),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  // Line level at a position within a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic frame_bit(logic [7:0] b, int pos);
    int slot;
    slot = pos / int'(CPB);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[3'(slot - 1)];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit full_pre;
    bit pop_now;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      full_pre = (mq.size() == int'(DEPTH));
      pop_now  = (mq.size() > 0) && (!m_active || m_pos == FRAME - 1);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (pop_now) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (wr_en) begin
        if (full_pre) m_ovf = 1'b1;
        else          mq.push_back(data_in);
      end
    end
  endtask

  // One clock: advance model with the inputs seen at this edge, then compare all outputs.
  task automatic tick();
    logic exp_tx;
    @(posedge clk);
    model_edge();
    #1;
    exp_tx = m_active ? frame_bit(m_cur, m_pos) : 1'b1;
    check("tx",       32'(tx),       32'(exp_tx));
    check("count",    32'(count),    32'(mq.size()));
    check("busy",     32'(busy),     32'(m_active || mq.size() > 0));
    check("full",     32'(full),     32'(mq.size() == int'(DEPTH)));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic write(logic [7:0] d);
    wr_en   = 1'b1;
    data_in = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((m_active || mq.size() > 0) && n < FRAME * (int'(DEPTH) + 3)) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic wait_pos(int pos, string tag);
    int n;
    n = 0;
    while (!(m_active && m_pos == pos) && n < 4 * FRAME) begin
      tick();
      n++;
    end
    check(tag, 32'(m_active && m_pos == pos), 32'(1));
  endtask

  initial begin
    // Reset state and idle line.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_count", 32'(count), 32'(0));
    repeat (100) tick();

    // Single byte 0xA5: tx falls at the edge after the write.
    write(8'hA5);
    check("a5_count_after_write", 32'(count), 32'(1));
    tick();
    check("a5_start_edge", 32'(tx), 32'(0));
    drain("a5_drain");

    // Back-to-back frames with no gap.
    write(8'h01);
    write(8'h80);
    drain("b2b_drain");

    // Overflow: six consecutive writes, the sixth dropped.
    for (int i = 0; i < 6; i++) begin
      write(8'(8'h10 + i));
      if (i == 4) check("ovf_full_after_5th", 32'(full), 32'(1));
    end
    check("ovf_sticky", 32'(overflow), 32'(1));
    drain("ovf_drain");
    check("ovf_still_set", 32'(overflow), 32'(1));
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'(0));

    // Dropped write on the final STOP cycle while a pop happens.
    for (int i = 0; i < 5; i++) write(8'(8'hC0 + i));
    check("fp_count4", 32'(count), 32'(4));
    wait_pos(FRAME - 1, "fp_reach_stop");
    write(8'h99);
    check("fp_count3", 32'(count), 32'(3));
    check("fp_ovf", 32'(overflow), 32'(1));
    drain("fp_drain");
    do_reset();

    // Reset during data bit 3 with two bytes queued.
    for (int i = 0; i < 3; i++) write(8'(8'h5A + i));
    wait_pos(4 * int'(CPB) + 1, "mr_reach_bit3");
    check("mr_queued", 32'(count), 32'(2));
    do_reset();
    check("mr_tx", 32'(tx), 32'(1));
    check("mr_count", 32'(count), 32'(0));
    check("mr_busy", 32'(busy), 32'(0));
    write(8'h3C);
    drain("mr_3c_drain");

    // Random traffic with varying write density and rare resets.
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < 700; c++) begin
        wr_en   = ($urandom_range(0, 99) < 3 + phase * 10);
        data_in = 8'($urandom);
        rst     = ($urandom_range(0, 499) == 0);
        tick();
      end
      wr_en = 1'b0;
      rst   = 1'b0;
      drain("rnd_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe (CPU OI control signal).
REQ-006 The block SHALL have port data_in, input, 8 bits: byte to transmit (CPU bus / register A value).
REQ-007 The block SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-008 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of bytes queued, not counting the byte in the shifter.
REQ-009 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE or count != 0; the CPU uses it to stall OUT.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-011 The block SHALL have port tx, output, 1 bit: registered serial line, idle high.

Function
REQ-012 A write SHALL be accepted at a rising edge when wr_en=1 and full=0, using the pre-edge full value; data_in SHALL be stored at the write pointer.
REQ-013 When wr_en=1 and full=1, the write SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged, even if a pop occurs at the same edge.
REQ-014 On a simultaneous accepted write and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-015 Pointers SHALL wrap modulo DEPTH; the FIFO SHALL be strictly first-in, first-out.
REQ-016 The transmitter FSM SHALL have states IDLE, START, DATA, STOP and a bit-timer counting 0..CLKS_PER_BIT-1.
REQ-017 In IDLE with count>0, the FSM SHALL pop the head entry into an 8-bit shifter at that edge, go to START, and drive tx=0.
REQ-018 In IDLE with count==0, tx SHALL be 1.
REQ-019 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-020 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index 0..7, then go to STOP.
REQ-021 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-022 On the final cycle of STOP, the FSM SHALL pop and go directly to START if count>0 (no idle gap between frames), and SHALL go to IDLE otherwise.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 Latency: a write accepted at edge E into an empty FIFO with the FSM in IDLE SHALL produce the falling start edge on tx at edge E+1.
REQ-025 wr_en SHALL be level-sampled every edge; holding it high for N edges SHALL attempt N writes.
REQ-026 The overflow flag SHALL be cleared only by rst.
REQ-027 tx SHALL be driven from a flop and SHALL never glitch.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set: tx=1, state=IDLE, bit-timer=0, bit index=0, pointers=0, count=0, full=0, busy=0, overflow=0.
REQ-029 Reset SHALL take priority over wr_en and over any pop.
REQ-030 Reset mid-frame SHALL abort the frame and drive tx=1 from the next cycle; queued bytes SHALL be discarded.
REQ-031 FIFO storage need not be cleared, but it SHALL be unobservable until written.

Verification
REQ-032 Single byte: CLKS_PER_BIT=4, write 0xA5 once while idle -> tx falls at the next edge, then emits 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles); busy drops on the final STOP cycle edge; count returns to 0.
REQ-033 Back-to-back: write 0x01 then 0x80 on consecutive edges -> 80 contiguous cycles: 0,1,0000000,1 then 0,0000000,1,1; no idle-high gap between frames.
REQ-034 Overflow: DEPTH=4, wr_en=1 for 6 consecutive edges with data 0x10..0x15 while idle -> 0x10..0x14 accepted and transmitted in order; 0x15 dropped; full=1 after the 5th edge; overflow=1 and stays 1 until rst.
REQ-035 Full with simultaneous pop: count=4 and STOP on its final cycle with wr_en=1 -> write dropped, overflow=1, count becomes 3.
REQ-036 Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> next cycle tx=1, count=0, busy=0; a new write of 0x3C then transmits normally.
REQ-037 Idle line: no writes for 100 cycles after reset -> tx=1, busy=0, count=0 throughout.
